// File: rtl/nco_phase_gen_if.sv
// Control and address bundle between the oscillator voice sequencer and the
// quadrature phase generator feeding the sine/cosine table.
interface nco_phase_gen_if #(
    parameter int PSZ = 32,
    parameter int ASZ = 10
) ();
    logic           ce;
    logic [PSZ-1:0] freq;
    logic           freq_wr;
    logic [ASZ-1:0] offs;
    logic           sync;
    logic           busy;
    logic [ASZ-1:0] a0;
    logic [ASZ-1:0] a1;
    logic           addr_stb;
    logic           dat_stb;
    logic           wrap;

    modport master (
        output ce, freq, freq_wr, offs, sync,
        input  busy, a0, a1, addr_stb, dat_stb, wrap
    );

    modport slave (
        input  ce, freq, freq_wr, offs, sync,
        output busy, a0, a1, addr_stb, dat_stb, wrap
    );
endinterface

// File: rtl/nco_phase_gen.sv
// Clock-enabled phase accumulator producing a primary/offset table address pair,
// with double-buffered frequency updates, hard sync and a table-latency data strobe.
module nco_phase_gen #(
    parameter int PSZ = 32,
    parameter int ASZ = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    nco_phase_gen_if.slave  bus
);
    logic [PSZ-1:0] phase_q, phase_d;
    logic [PSZ-1:0] inc_q, inc_d;
    logic [PSZ-1:0] pend_q, pend_d;
    logic           pend_v_q, pend_v_d;
    logic           sync_p_q, sync_p_d;
    logic [ASZ-1:0] a0_q, a0_d;
    logic [ASZ-1:0] a1_q, a1_d;
    logic           wrap_q, wrap_d;
    logic           addr_stb_q;
    logic           stb_d_q;
    logic           dat_stb_q;

    logic [PSZ:0]   sum;
    logic [ASZ-1:0] sum_addr;
    logic           sync_hit;

    // The extra MSB of the sum is the accumulator carry, reported as wrap.
    assign sum      = {1'b0, phase_q} + {1'b0, inc_q};
    assign sum_addr = sum[PSZ-1 -: ASZ];
    assign sync_hit = bus.sync | sync_p_q;

    always_comb begin
        phase_d  = phase_q;
        inc_d    = inc_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        sync_p_d = sync_p_q;
        a0_d     = a0_q;
        a1_d     = a1_q;
        wrap_d   = wrap_q;

        if (bus.ce) begin
            // The step itself still uses inc_q; a pending word takes over next ce.
            if (pend_v_q) begin
                inc_d    = pend_q;
                pend_v_d = 1'b0;
            end
            if (sync_hit) begin
                phase_d  = '0;
                a0_d     = '0;
                a1_d     = bus.offs;
                wrap_d   = 1'b1;
                sync_p_d = 1'b0;
            end else begin
                phase_d = sum[PSZ-1:0];
                a0_d    = sum_addr;
                a1_d    = sum_addr + bus.offs;
                wrap_d  = sum[PSZ];
            end
        end else if (bus.sync) begin
            sync_p_d = 1'b1;
        end

        // A write always lands in pend, so a write coincident with ce stays pending.
        if (bus.freq_wr) begin
            pend_d   = bus.freq;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            inc_q      <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            sync_p_q   <= 1'b0;
            a0_q       <= '0;
            a1_q       <= '0;
            wrap_q     <= 1'b0;
            addr_stb_q <= 1'b0;
            stb_d_q    <= 1'b0;
            dat_stb_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            inc_q      <= inc_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            sync_p_q   <= sync_p_d;
            a0_q       <= a0_d;
            a1_q       <= a1_d;
            wrap_q     <= wrap_d;
            addr_stb_q <= bus.ce;
            stb_d_q    <= addr_stb_q;
            dat_stb_q  <= stb_d_q;
        end
    end

    assign bus.busy     = pend_v_q;
    assign bus.a0       = a0_q;
    assign bus.a1       = a1_q;
    assign bus.wrap     = wrap_q;
    assign bus.addr_stb = addr_stb_q;
    assign bus.dat_stb  = dat_stb_q;
endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed scoreboard bench for nco_phase_gen: stimulus pushes hand-computed
// address expectations, a monitor pops and compares them on every addr_stb.
module tb_nco_phase_gen;
    localparam int PSZ = 32;
    localparam int ASZ = 10;

    typedef struct packed {
        logic [ASZ-1:0] a0;
        logic [ASZ-1:0] a1;
        logic           wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    nco_phase_gen_if #(.PSZ(PSZ), .ASZ(ASZ)) bus ();

    nco_phase_gen #(.PSZ(PSZ), .ASZ(ASZ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One ce cycle, optionally with a coincident freq write and/or sync.
    task automatic do_ce(input logic wr, input logic [PSZ-1:0] f, input logic sy,
                         input logic [ASZ-1:0] ea0, input logic [ASZ-1:0] ea1,
                         input logic ew);
        exp_t e;
        e.a0 = ea0;
        e.a1 = ea1;
        e.wrap = ew;
        exp_q.push_back(e);
        bus.ce = 1'b1;
        bus.freq_wr = wr;
        bus.freq = f;
        bus.sync = sy;
        @(negedge clk);
        bus.ce = 1'b0;
        bus.freq_wr = 1'b0;
        bus.sync = 1'b0;
    endtask

    task automatic write_freq(input logic [PSZ-1:0] f);
        bus.freq = f;
        bus.freq_wr = 1'b1;
        @(negedge clk);
        bus.freq_wr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a0"}, 32'(bus.a0), 32'd0);
        chk({tag, ".a1"}, 32'(bus.a1), 32'd0);
        chk({tag, ".addr_stb"}, 32'(bus.addr_stb), 32'd0);
        chk({tag, ".dat_stb"}, 32'(bus.dat_stb), 32'd0);
        chk({tag, ".wrap"}, 32'(bus.wrap), 32'd0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Monitor: every address strobe consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.addr_stb) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_addr_stb", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("step a0=0x%03h a1=0x%03h wrap=%0d (req 0x%03h 0x%03h %0d)",
                         bus.a0, bus.a1, bus.wrap, e.a0, e.a1, e.wrap);
                chk("a0", 32'(bus.a0), 32'(e.a0));
                chk("a1", 32'(bus.a1), 32'(e.a1));
                chk("wrap", 32'(bus.wrap), 32'(e.wrap));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ASZ-1:0] na;
        bus.ce = 1'b0;
        bus.freq = '0;
        bus.freq_wr = 1'b0;
        bus.offs = '0;
        bus.sync = 1'b0;

        // Reset state, then idle after release.
        idle(3);
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(4);
        chk_all_zero("post_reset_idle");

        // Ramp: one address LSB per step, cosine offset.
        bus.offs = 10'h100;
        write_freq(32'h0040_0000);
        chk("ramp_busy_set", 32'(bus.busy), 32'd1);
        for (int n = 0; n <= 1027; n++) begin
            na = 10'(n);
            do_ce(1'b0, '0, 1'b0, na, na + 10'h100, n == 1024);
            if (n == 0) chk("ramp_busy_clr", 32'(bus.busy), 32'd0);
            if (n == 5) begin
                chk("lat_addr_stb_k1", 32'(bus.addr_stb), 32'd1);
                chk("lat_dat_stb_k1", 32'(bus.dat_stb), 32'd0);
                @(negedge clk);
                chk("lat_addr_stb_k2", 32'(bus.addr_stb), 32'd0);
                chk("lat_dat_stb_k2", 32'(bus.dat_stb), 32'd0);
                @(negedge clk);
                chk("lat_dat_stb_k3", 32'(bus.dat_stb), 32'd1);
                @(negedge clk);
                chk("lat_dat_stb_k4", 32'(bus.dat_stb), 32'd0);
            end else begin
                idle(3);
            end
        end

        // Double buffer: last write wins, applied step still uses old inc.
        write_freq(32'h0040_0000);
        idle(1);
        write_freq(32'h0080_0000);
        idle(1);
        chk("dbuf_busy", 32'(bus.busy), 32'd1);
        do_ce(1'b0, '0, 1'b0, 10'd4, 10'd260, 1'b0);
        chk("dbuf_busy_clr", 32'(bus.busy), 32'd0);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd6, 10'd262, 1'b0);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd8, 10'd264, 1'b0);
        idle(3);

        // freq_wr coincident with ce: applied one ce later.
        do_ce(1'b1, 32'h00C0_0000, 1'b0, 10'd10, 10'd266, 1'b0);
        chk("coinc_busy_1", 32'(bus.busy), 32'd1);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd12, 10'd268, 1'b0);
        chk("coinc_busy_2", 32'(bus.busy), 32'd0);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd15, 10'd271, 1'b0);
        idle(3);

        // Coincident write while already pending: older applies, newer pends.
        write_freq(32'h0040_0000);
        do_ce(1'b1, 32'h0080_0000, 1'b0, 10'd18, 10'd274, 1'b0);
        chk("pend_coinc_busy", 32'(bus.busy), 32'd1);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd19, 10'd275, 1'b0);
        chk("pend_coinc_busy_clr", 32'(bus.busy), 32'd0);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd21, 10'd277, 1'b0);
        idle(3);

        // Sync between ce pulses, then sync coincident with ce.
        bus.sync = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        idle(2);
        do_ce(1'b0, '0, 1'b0, 10'd0, 10'h100, 1'b1);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd2, 10'd258, 1'b0);
        idle(3);
        bus.offs = 10'h080;
        do_ce(1'b0, '0, 1'b1, 10'd0, 10'h080, 1'b1);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd2, 10'h082, 1'b0);
        idle(3);

        // Mid-run async reset discards pending freq and pending sync.
        write_freq(32'h00C0_0000);
        bus.sync = 1'b1;
        @(negedge clk);
        bus.sync = 1'b0;
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        chk_all_zero("release_idle");
        do_ce(1'b0, '0, 1'b0, 10'd0, 10'h080, 1'b0);
        idle(3);
        do_ce(1'b0, '0, 1'b0, 10'd0, 10'h080, 1'b0);
        idle(4);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
